if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised fetch-to-decode instruction queue, the successor to the single-entry IF/ID pipeline register. It buffers up to DEPTH fetched (pc, instruction) pairs between the instruction-fetch stage and the decoder, using valid/ready handshakes on both sides, so fetch can run ahead while decode stalls. A jump/branch flush discards all buffered entries in one cycle. The global `rdy` input freezes all state.

## Interface
- ADDR_LEN, 32, width of program counter
- INST_LEN, 32, width of instruction word
- DEPTH, 4, number of entries; power of two, >= 2
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- rdy  input  1  global ready/clock-enable; when low, no state changes (reset excepted)
- flush  input  1  jump taken; discard all entries and any same-cycle enqueue
- if_valid  input  1  fetch offers (if_pc, if_inst) this cycle
- if_pc  input  ADDR_LEN  pc of offered instruction
- if_inst  input  INST_LEN  offered instruction
- if_ready  output  1  queue can accept an entry (not full)
- id_valid  output  1  head entry valid (queue not empty)
- id_pc  output  ADDR_LEN  pc of head entry; 0 when empty
- id_inst  output  INST_LEN  head instruction; 0 when empty
- id_ready  input  1  decoder consumes head this cycle
- count  output  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: DEPTH-entry circular buffer, write pointer wp, read pointer rp (log2(DEPTH) bits, wrap naturally modulo DEPTH), occupancy counter count.
- Enqueue fires when rdy && if_valid && if_ready && !flush: mem[wp] <= {if_pc, if_inst}, wp <= wp+1.
- Dequeue fires when rdy && id_valid && id_ready && !flush: rp <= rp+1.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- if_ready = (count != DEPTH); combinational from registered count, independent of id_ready (no pass-through when full).
- id_valid = (count != 0); id_pc/id_inst = mem[rp] when id_valid, else 0 (first-word fall-through from registers).
- Flush (rdy && flush): wp, rp, count <= 0; same-cycle enqueue and dequeue both suppressed. Storage contents need not be cleared.
- rdy low: pointers, count, storage held; flush/if_valid/id_ready ignored; outputs remain the registered view.
- rst (regardless of rdy): wp, rp, count <= 0. Outputs after reset: if_ready=1, id_valid=0, id_pc=0, id_inst=0, count=0.
- Enqueue while id_ready asserted on empty queue: no dequeue that cycle (id_valid was 0); entry appears next cycle.
- Overflow/underflow impossible by construction: enqueue gated by if_ready, dequeue by id_valid.

## Timing
- Enqueue-to-visible latency: 1 cycle (entry written at edge N appears on id_* after edge N if queue was empty).
- Throughput: 1 enqueue and 1 dequeue per cycle sustained when 0 < count < DEPTH.
- Full: simultaneous dequeue frees a slot; if_ready rises the cycle after.
- Empty: simultaneous enqueue; id_valid rises the cycle after.
- Flush takes effect at the edge where it is sampled; next cycle id_valid=0, if_ready=1, count=0.
- All outputs derived from registered state only; no combinational path from if_valid/id_ready/flush to any output.

## Test plan
- Reset: assert rst 2 cycles with if_valid=1 -> count=0, id_valid=0, if_ready=1, id_pc=id_inst=0.
- Fill and drain, DEPTH=4: enqueue pcs 0x00,0x04,0x08,0x0C with id_ready=0 -> count=4, if_ready=0, fifth offer (0x10) not taken; then id_ready=1 -> id_pc sequence 0x00,0x04,0x08,0x0C, then id_valid=0.
- Streaming with wrap: if_valid=id_ready=1 for 10 cycles, pcs 0x100+4k -> count stays 1 after first cycle, id_pc presented in order 0x100..0x124 across pointer wrap.
- Flush with concurrent traffic: count=3, assert flush with if_valid=1 and id_ready=1 -> next cycle count=0, id_valid=0; offered entry absent; following enqueue of 0x200 appears as head.
- rdy gating: count=2, drive rdy=0 with flush=1, if_valid=1, id_ready=1 for 3 cycles -> count, id_pc, id_inst unchanged; rdy=1 resumes normally.
- Full with simultaneous deq/enq offer: count=4, id_ready=1, if_valid=1 -> one dequeue, no enqueue; count=3, if_ready=1 next cycle.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface if_id_queue_if #(
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                if_valid;
  logic [ADDR_LEN-1:0] if_pc;
  logic [INST_LEN-1:0] if_inst;
  logic                if_ready;
  logic                id_valid;
  logic [ADDR_LEN-1:0] id_pc;
  logic [INST_LEN-1:0] id_inst;
  logic                id_ready;
  logic [CNT_W-1:0]    count;

  modport slave (
    input  if_valid, if_pc, if_inst, id_ready,
    output if_ready, id_valid, id_pc, id_inst, count
  );

  modport master (
    output if_valid, if_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, count
  );
endinterface

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer with first-word
// fall-through, one-cycle flush and a global rdy freeze.
module if_id_queue #(
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32,
  parameter int DEPTH    = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           rdy_i,
  input  logic           flush_i,
  if_id_queue_if.slave   q_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_LEN + INST_LEN;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, enq, deq;
  logic [ENT_W-1:0] head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Handshakes only qualify on registered occupancy, so no input reaches an output.
  assign enq = rdy_i && q_if.if_valid && !full  && !flush_i;
  assign deq = rdy_i && q_if.id_ready && !empty && !flush_i;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (rdy_i) begin
      if (flush_i) begin
        wp_d    = '0;
        rp_d    = '0;
        count_d = '0;
      end else begin
        if (enq) wp_d = wp_q + 1'b1;
        if (deq) rp_d = rp_q + 1'b1;
        if (enq && !deq)      count_d = count_q + 1'b1;
        else if (deq && !enq) count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; the empty-case output mux hides stale contents.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wp_q] <= {q_if.if_pc, q_if.if_inst};
  end

  assign head = empty ? '0 : mem_q[rp_q];

  assign q_if.if_ready = !full;
  assign q_if.id_valid = !empty;
  assign q_if.id_pc    = head[ENT_W-1:INST_LEN];
  assign q_if.id_inst  = head[INST_LEN-1:0];
  assign q_if.count    = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for if_id_queue (DEPTH=4) plus a streaming wrap sequence.
module tb_if_id_queue;
  localparam int AL = 32;
  localparam int IL = 32;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst, rdy, flush;

  if_id_queue_if #(.ADDR_LEN(AL), .INST_LEN(IL), .DEPTH(DP)) qif ();

  if_id_queue #(.ADDR_LEN(AL), .INST_LEN(IL), .DEPTH(DP)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .rdy_i   (rdy),
    .flush_i (flush),
    .q_if    (qif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, flush, iv, idr;
    logic [31:0] pc;
    logic [2:0]  ecnt;
    logic        evalid, eready;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return pc ^ 32'hA5A5_1234;
  endfunction

  task automatic addv(input logic r, input logic y, input logic f, input logic iv,
                      input logic [31:0] pc, input logic idr, input logic [2:0] ecnt,
                      input logic ev, input logic er, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.rdy = y; v.flush = f; v.iv = iv; v.pc = pc; v.idr = idr;
    v.ecnt = ecnt; v.evalid = ev; v.eready = er; v.epc = epc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic y, input logic f, input logic iv,
                       input logic [31:0] pc, input logic idr);
    rst = r; rdy = y; flush = f;
    qif.if_valid = iv; qif.if_pc = pc; qif.if_inst = inst_of(pc); qif.id_ready = idr;
  endtask

  task automatic check(input string name, input logic [2:0] ecnt, input logic ev,
                       input logic er, input logic [31:0] epc);
    logic [31:0] einst;
    einst = ev ? inst_of(epc) : 32'h0;
    tests++;
    if (qif.count !== ecnt || qif.id_valid !== ev || qif.if_ready !== er ||
        qif.id_pc !== epc || qif.id_inst !== einst) begin
      fails++;
      $display("FAIL %s: got cnt=%0d vld=%b rdy=%b pc=%h inst=%h, want cnt=%0d vld=%b rdy=%b pc=%h inst=%h",
               name, qif.count, qif.id_valid, qif.if_ready, qif.id_pc, qif.id_inst,
               ecnt, ev, er, epc, einst);
    end
  endtask

  initial begin
    // reset with an offer pending
    addv(1,1,0,1,32'h50,0, 0,0,1,32'h0);
    addv(1,1,0,1,32'h54,0, 0,0,1,32'h0);
    // fill to DEPTH, fifth offer refused
    addv(0,1,0,1,32'h00,0, 1,1,1,32'h00);
    addv(0,1,0,1,32'h04,0, 2,1,1,32'h00);
    addv(0,1,0,1,32'h08,0, 3,1,1,32'h00);
    addv(0,1,0,1,32'h0C,0, 4,1,0,32'h00);
    addv(0,1,0,1,32'h10,0, 4,1,0,32'h00);
    // drain in order
    addv(0,1,0,0,32'h0,1, 3,1,1,32'h04);
    addv(0,1,0,0,32'h0,1, 2,1,1,32'h08);
    addv(0,1,0,0,32'h0,1, 1,1,1,32'h0C);
    addv(0,1,0,0,32'h0,1, 0,0,1,32'h00);
    // refill; full with dequeue + offer: only the dequeue fires
    addv(0,1,0,1,32'h20,0, 1,1,1,32'h20);
    addv(0,1,0,1,32'h24,0, 2,1,1,32'h20);
    addv(0,1,0,1,32'h28,0, 3,1,1,32'h20);
    addv(0,1,0,1,32'h2C,0, 4,1,0,32'h20);
    addv(0,1,0,1,32'h30,1, 3,1,1,32'h24);
    addv(0,1,0,1,32'h30,1, 3,1,1,32'h28);
    addv(0,1,0,1,32'h34,1, 3,1,1,32'h2C);
    // flush at count=3 with concurrent traffic, then fresh enqueue becomes head
    addv(0,1,1,1,32'h38,1, 0,0,1,32'h00);
    addv(0,1,0,1,32'h200,0, 1,1,1,32'h200);
    addv(0,1,0,0,32'h0,1, 0,0,1,32'h00);
    // rdy gating at count=2
    addv(0,1,0,1,32'h300,0, 1,1,1,32'h300);
    addv(0,1,0,1,32'h304,0, 2,1,1,32'h300);
    addv(0,0,1,1,32'h308,1, 2,1,1,32'h300);
    addv(0,0,1,1,32'h308,1, 2,1,1,32'h300);
    addv(0,0,1,1,32'h308,1, 2,1,1,32'h300);
    addv(0,1,0,0,32'h0,1, 1,1,1,32'h304);
    // reset wins even while frozen
    addv(1,0,0,0,32'h0,0, 0,0,1,32'h00);

    drive(1,1,0,0,32'h0,0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].idr);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].evalid, vecs[i].eready, vecs[i].epc);
    end

    // streaming across pointer wrap: count holds at 1, heads in order
    for (int k = 0; k < 10; k++) begin
      drive(0,1,0,1,32'h100 + 32'(4*k),1);
      @(posedge clk); #1;
      check($sformatf("stream%0d", k), 3'd1, 1'b1, 1'b1, 32'h100 + 32'(4*k));
    end
    drive(0,1,0,0,32'h0,1);
    @(posedge clk); #1;
    check("stream_drain", 3'd0, 1'b0, 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
